zero_pad_sched: RTL and testbench

Two-input packet scheduler and length controller for the zero-padding datapath in an RFNoC compute-engine block. Arbitrates round-robin between two AXI-stream sample sources at packet boundaries. Forces every granted packet to a runtime-programmable length by appending zero words or truncating excess words. Output length is set over the settings bus; sits between axi_wrapper outputs and the downstream header-modify/s_axis path.

---
 rtl/zero_pad_sched.sv | 154 +++++++++++++++
 tb/tb_zero_pad_sched.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zero_pad_sched.sv
// Two-input round-robin packet scheduler that forces every granted packet to a
// programmable length, appending zero words or discarding the excess.
module zero_pad_sched #(
  parameter int         WIDTH         = 32,
  parameter int         LEN_W         = 16,
  parameter logic [7:0] SR_OUT_LEN    = 8'd129,
  parameter int         DEFAULT_OUT_L = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set_stb,
  input  logic [7:0]       set_addr,
  input  logic [31:0]      set_data,
  input  logic [WIDTH-1:0] i0_tdata,
  input  logic             i0_tlast,
  input  logic             i0_tvalid,
  output logic             i0_tready,
  input  logic [WIDTH-1:0] i1_tdata,
  input  logic             i1_tlast,
  input  logic             i1_tvalid,
  output logic             i1_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic             o_src,
  output logic [31:0]      padded_cnt,
  output logic [31:0]      trunc_cnt
);

  typedef enum logic [1:0] {IDLE, PASS, PAD, DROP} state_t;

  state_t           state, state_nxt;
  logic             src, last_grant;
  logic [LEN_W-1:0] cnt, act_len, out_len;

  logic             grant, grant_src;
  logic             out_xfer, pad_done, trunc_done, sel_ready;
  logic [WIDTH-1:0] sel_tdata;
  logic             sel_tvalid, sel_tlast;
  logic             len_zero, at_last;

  // Only the low LEN_W bits of a settings word carry the length.
  logic unused_set_bits;
  assign unused_set_bits = &{1'b0, set_data[31:LEN_W]};

  assign sel_tdata  = src ? i1_tdata  : i0_tdata;
  assign sel_tvalid = src ? i1_tvalid : i0_tvalid;
  assign sel_tlast  = src ? i1_tlast  : i0_tlast;

  assign len_zero = (act_len == '0);
  assign at_last  = !len_zero && (cnt == act_len - LEN_W'(1));

  assign i0_tready = sel_ready & ~src;
  assign i1_tready = sel_ready &  src;
  assign o_src     = src;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_nxt  = state;
    o_tdata    = '0;
    o_tvalid   = 1'b0;
    o_tlast    = 1'b0;
    sel_ready  = 1'b0;
    grant      = 1'b0;
    grant_src  = 1'b0;
    out_xfer   = 1'b0;
    pad_done   = 1'b0;
    trunc_done = 1'b0;

    unique case (state)
      IDLE: begin
        if (i0_tvalid && i1_tvalid) begin
          grant     = 1'b1;
          grant_src = ~last_grant;
        end else if (i0_tvalid || i1_tvalid) begin
          grant     = 1'b1;
          grant_src = i1_tvalid;
        end
        if (grant) state_nxt = PASS;
      end

      PASS: begin
        o_tdata   = sel_tdata;
        o_tvalid  = sel_tvalid;
        sel_ready = o_tready;
        o_tlast   = at_last || (len_zero && sel_tlast);
        out_xfer  = sel_tvalid && o_tready;
        if (out_xfer) begin
          if (len_zero) begin
            if (sel_tlast) state_nxt = IDLE;
          end else if (at_last) begin
            state_nxt = sel_tlast ? IDLE : DROP;
          end else if (sel_tlast) begin
            state_nxt = PAD;
          end
        end
      end

      // Zero fill holds valid high regardless of o_tready until the final word.
      PAD: begin
        o_tvalid = 1'b1;
        o_tlast  = at_last;
        out_xfer = o_tready;
        if (out_xfer && at_last) begin
          pad_done  = 1'b1;
          state_nxt = IDLE;
        end
      end

      DROP: begin
        sel_ready = 1'b1;
        if (sel_tvalid && sel_tlast) begin
          trunc_done = 1'b1;
          state_nxt  = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every register see pre-edge values of the others.
    if (reset) begin
      state      <= IDLE;
      src        <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
      act_len    <= '0;
      out_len    <= LEN_W'(DEFAULT_OUT_L);
      padded_cnt <= '0;
      trunc_cnt  <= '0;
    end else begin
      state <= state_nxt;

      if (set_stb && set_addr == SR_OUT_LEN) out_len <= set_data[LEN_W-1:0];

      // The length is frozen per packet so mid-packet writes only affect the next one.
      if (grant) begin
        src        <= grant_src;
        last_grant <= grant_src;
        cnt        <= '0;
        act_len    <= out_len;
      end else if (out_xfer) begin
        cnt <= cnt + LEN_W'(1);
      end

      if (pad_done   && padded_cnt != '1) padded_cnt <= padded_cnt + 32'd1;
      if (trunc_done && trunc_cnt  != '1) trunc_cnt  <= trunc_cnt  + 32'd1;
    end
  end

endmodule

// File: tb/tb_zero_pad_sched.sv
// Directed scoreboard bench for zero_pad_sched: expected output words are queued
// as each packet is launched and popped by a monitor on every output transfer.
module tb_zero_pad_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic [31:0] i0_tdata, i1_tdata, o_tdata;
  logic        i0_tlast, i0_tvalid, i0_tready;
  logic        i1_tlast, i1_tvalid, i1_tready;
  logic        o_tlast, o_tvalid, o_tready, o_src;
  logic [31:0] padded_cnt, trunc_cnt;

  always #5 clk = ~clk;

  zero_pad_sched dut (
    .clk       (clk),
    .reset     (reset),
    .set_stb   (set_stb),
    .set_addr  (set_addr),
    .set_data  (set_data),
    .i0_tdata  (i0_tdata),
    .i0_tlast  (i0_tlast),
    .i0_tvalid (i0_tvalid),
    .i0_tready (i0_tready),
    .i1_tdata  (i1_tdata),
    .i1_tlast  (i1_tlast),
    .i1_tvalid (i1_tvalid),
    .i1_tready (i1_tready),
    .o_tdata   (o_tdata),
    .o_tlast   (o_tlast),
    .o_tvalid  (o_tvalid),
    .o_tready  (o_tready),
    .o_src     (o_src),
    .padded_cnt(padded_cnt),
    .trunc_cnt (trunc_cnt)
  );

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        src;
    logic        pad;
  } exp_t;

  exp_t sb[$];
  int   tlast_cyc[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   xfer_cnt = 0;
  int   rdy_novalid = 0;
  int   exp_pad = 0;
  int   exp_trunc = 0;
  bit   prev_hold = 1'b0;
  bit   throttle = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit which, input bit v, input logic [31:0] d, input bit l);
    if (which) begin
      i1_tvalid = v; i1_tdata = d; i1_tlast = l;
    end else begin
      i0_tvalid = v; i0_tdata = d; i0_tlast = l;
    end
  endtask

  task automatic set_reg(input logic [7:0] addr, input logic [31:0] val);
    set_stb = 1'b1; set_addr = addr; set_data = val;
    tick(1);
    set_stb = 1'b0;
  endtask

  // Reference model of one granted packet at latched length len.
  task automatic push_pkt(input bit s, input int n, input logic [31:0] base, input int len);
    exp_t e;
    if (len == 0) begin
      for (int k = 0; k < n; k++) begin
        e.data = base + k; e.last = (k == n - 1); e.src = s; e.pad = 1'b0;
        sb.push_back(e);
      end
    end else begin
      for (int k = 0; k < len; k++) begin
        e.data = (k < n) ? base + k : 32'd0;
        e.last = (k == len - 1); e.src = s; e.pad = (k >= n);
        sb.push_back(e);
      end
      if (n < len) exp_pad++;
      if (n > len) exp_trunc++;
    end
  endtask

  task automatic send_pkt(input bit which, input int n, input logic [31:0] base, input int budget);
    int k = 0;
    int c = 0;
    bit hs;
    drive(which, 1'b1, base, n == 1);
    while (k < n && c < budget) begin
      @(negedge clk);
      hs = which ? (i1_tvalid && i1_tready) : (i0_tvalid && i0_tready);
      @(posedge clk); #1;
      c++;
      if (hs) begin
        k++;
        if (k < n) drive(which, 1'b1, base + k, k == n - 1);
      end
    end
    drive(which, 1'b0, 32'd0, 1'b0);
    check(which ? "i1_words_accepted" : "i0_words_accepted", k, n);
  endtask

  task automatic drain(input string tag, input int budget);
    int c = 0;
    while (sb.size() != 0 && c < budget) begin
      tick(1);
      c++;
    end
    check({tag, "_drained"}, sb.size(), 0);
    tick(2);
  endtask

  // Monitor: every output transfer must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) check("pad_valid_held", o_tvalid, 1'b1);
      if (o_tvalid && o_tready) begin
        if (sb.size() == 0) begin
          check("unexpected_word", o_tvalid, 1'b0);
        end else begin
          e = sb.pop_front();
          check("o_tdata", o_tdata, e.data);
          check("o_tlast", o_tlast, e.last);
          check("o_src", o_src, e.src);
        end
        xfer_cnt++;
        if (o_tlast) tlast_cyc.push_back(cyc);
        prev_hold = 1'b0;
      end else begin
        prev_hold = o_tvalid && !o_tready && sb.size() != 0 && sb[0].pad;
      end
      if (i1_tready && !o_tvalid) rdy_novalid++;
    end
  end

  always begin
    @(posedge clk); #1;
    if (throttle) o_tready = 1'($urandom_range(0, 1));
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_x;
    int c;
    reset = 1'b1; set_stb = 1'b0; set_addr = '0; set_data = '0;
    o_tready = 1'b0;
    drive(1'b0, 1'b0, 32'd0, 1'b0);
    drive(1'b1, 1'b0, 32'd0, 1'b0);
    tick(3);
    check("rst_o_tvalid", o_tvalid, 1'b0);
    check("rst_o_tlast", o_tlast, 1'b0);
    check("rst_o_tdata", o_tdata, 32'd0);
    check("rst_o_src", o_src, 1'b0);
    check("rst_i0_tready", i0_tready, 1'b0);
    check("rst_i1_tready", i1_tready, 1'b0);
    check("rst_padded", padded_cnt, 32'd0);
    check("rst_trunc", trunc_cnt, 32'd0);
    reset = 1'b0;
    o_tready = 1'b1;
    tick(2);

    // Default length 32: 20-word packet padded with 12 zeros.
    push_pkt(1'b0, 20, 32'd1, 32);
    send_pkt(1'b0, 20, 32'd1, 100);
    drain("t1", 100);
    check("t1_padded", padded_cnt, exp_pad);
    check("t1_trunc", trunc_cnt, exp_trunc);

    // Length 8: 12-word packet truncated, 4 excess words dropped.
    set_reg(8'd129, 32'd8);
    set_reg(8'd130, 32'd5);
    rdy_novalid = 0;
    push_pkt(1'b1, 12, 32'h100, 8);
    send_pkt(1'b1, 12, 32'h100, 100);
    drain("t2", 100);
    check("t2_trunc", trunc_cnt, exp_trunc);
    check("t2_padded", padded_cnt, exp_pad);
    check("t2_drop_cycles", rdy_novalid, 4);
    check("t2_idle_valid", o_tvalid, 1'b0);
    check("t2_idle_ready", i1_tready, 1'b0);

    // Both inputs continuously valid, exact-length packets alternate.
    set_reg(8'd129, 32'd4);
    tlast_cyc.delete();
    push_pkt(1'b0, 4, 32'h200, 4);
    push_pkt(1'b1, 4, 32'h300, 4);
    push_pkt(1'b0, 4, 32'h210, 4);
    push_pkt(1'b1, 4, 32'h310, 4);
    fork
      begin
        send_pkt(1'b0, 4, 32'h200, 100);
        send_pkt(1'b0, 4, 32'h210, 100);
      end
      begin
        send_pkt(1'b1, 4, 32'h300, 100);
        send_pkt(1'b1, 4, 32'h310, 100);
      end
    join
    drain("t3", 100);
    check("t3_pkt_count", tlast_cyc.size(), 4);
    for (int i = 1; i < tlast_cyc.size(); i++)
      check("t3_pkt_period", tlast_cyc[i] - tlast_cyc[i-1], 5);
    check("t3_padded", padded_cnt, exp_pad);

    // Length change during a 32-word pad only affects the following packet.
    set_reg(8'd129, 32'd32);
    push_pkt(1'b0, 4, 32'h400, 32);
    send_pkt(1'b0, 4, 32'h400, 100);
    tick(8);
    set_reg(8'd129, 32'd16);
    push_pkt(1'b0, 3, 32'h500, 16);
    send_pkt(1'b0, 3, 32'h500, 100);
    drain("t4", 100);
    check("t4_padded", padded_cnt, exp_pad);

    // Length 0 passes the packet through untouched.
    set_reg(8'd129, 32'd0);
    push_pkt(1'b0, 5, 32'h600, 0);
    send_pkt(1'b0, 5, 32'h600, 100);
    drain("t5a", 100);
    check("t5_padded_same", padded_cnt, exp_pad);
    check("t5_trunc_same", trunc_cnt, exp_trunc);

    // Random output backpressure through pass and pad phases.
    set_reg(8'd129, 32'd32);
    push_pkt(1'b1, 6, 32'h700, 32);
    throttle = 1'b1;
    send_pkt(1'b1, 6, 32'h700, 300);
    drain("t5b", 400);
    throttle = 1'b0;
    tick(1);
    o_tready = 1'b1;
    tick(1);
    check("t5_padded", padded_cnt, exp_pad);

    // Reset while presenting pad word 25 of a 40-word packet.
    set_reg(8'd129, 32'd40);
    push_pkt(1'b0, 10, 32'h800, 40);
    base_x = xfer_cnt;
    send_pkt(1'b0, 10, 32'h800, 100);
    c = 0;
    while (xfer_cnt - base_x < 24 && c < 200) begin
      tick(1);
      c++;
    end
    check("t6_reached_word25", xfer_cnt - base_x, 24);
    o_tready = 1'b0;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    sb.delete();
    exp_pad = 0;
    exp_trunc = 0;
    check("t6_o_tvalid", o_tvalid, 1'b0);
    check("t6_i0_tready", i0_tready, 1'b0);
    check("t6_padded", padded_cnt, 32'd0);
    check("t6_trunc", trunc_cnt, 32'd0);
    o_tready = 1'b1;
    tick(4);
    check("t6_no_trailing_pad", o_tvalid, 1'b0);

    // Default length restored and input 0 wins the first tie.
    push_pkt(1'b0, 2, 32'h900, 32);
    push_pkt(1'b1, 2, 32'hA00, 32);
    fork
      send_pkt(1'b0, 2, 32'h900, 100);
      send_pkt(1'b1, 2, 32'hA00, 100);
    join
    drain("t6", 100);
    check("t6_padded_after", padded_cnt, exp_pad);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
